branch_cmp_sched: RTL and testbench
===================================

Name: branch_cmp_sched

Overview:
- Sequences and time-shares one external branch comparator (EQ/LT, signed/unsigned select) between two requesters.
- Requester 0 is the branch unit: it supplies funct3 and gets back a taken decision.
- Requester 1 is the SLT/SLTU path: it supplies a signedness bit and gets back a 1-bit less-than result.
- Sits between decode/execute and the comparator instance; enables a multi-cycle core to keep a single comparator.

Parameters:
- XLEN, 32, operand width.
- RR_INIT, 0, requester favoured by round-robin after reset (0 = branch, 1 = slt).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- br_req_valid  in  1  branch request valid.
- br_req_ready  out  1  branch request accepted this cycle.
- br_funct3  in  3  RV32I branch funct3.
- br_a  in  XLEN  branch operand rs1.
- br_b  in  XLEN  branch operand rs2.
- br_rsp_valid  out  1  branch response valid.
- br_rsp_ready  in  1  branch response consumed.
- br_taken  out  1  branch taken.
- br_illegal  out  1  funct3 was 010 or 011.
- slt_req_valid  in  1  slt request valid.
- slt_req_ready  out  1  slt request accepted.
- slt_unsigned  in  1  1 = SLTU, 0 = SLT.
- slt_a  in  XLEN  slt operand a.
- slt_b  in  XLEN  slt operand b.
- slt_rsp_valid  out  1  slt response valid.
- slt_rsp_ready  in  1  slt response consumed.
- slt_result  out  1  a<b.
- cmp_a  out  XLEN  operand to comparator.
- cmp_b  out  XLEN  operand to comparator.
- cmp_unsign  out  1  comparator unsigned select.
- cmp_eq  in  1  comparator equal (combinational from cmp_a/cmp_b).
- cmp_lt  in  1  comparator less-than.
- stat_br_cnt  out  32  branches resolved (CMP_STATS_EN only, else 0).
- stat_taken_cnt  out  32  branches taken (CMP_STATS_EN only, else 0).

Behaviour:
- Reset: one clock, clk; reset rst_n is asynchronous, active-low. FSM=IDLE; all outputs 0; operand registers 0; rr pointer=RR_INIT; stats 0.
- States:
  - IDLE: req_ready is combinationally high for the granted requester only. Grant rule: if exactly one valid, grant it; if both valid, grant the rr-favoured one. On grant, capture operands, unsign bit (branch: funct3[1]) and owner; flip rr pointer to the other requester; go to CMP.
  - CMP: cmp_a/cmp_b/cmp_unsign are driven from the capture registers (zero in all other states). At clock end, sample cmp_eq/cmp_lt and compute the result; go to RESP.
  - RESP: owner's rsp_valid is held high with a stable result until its rsp_ready. On the handshake, go to IDLE. No new request is accepted in CMP or RESP.
- Latency: request accepted at cycle N; rsp_valid at N+2; earliest next accept N+3 (rsp_ready high at N+2). Throughput 1 per 3 cycles.
- Branch decode:
  - 000: taken=eq.
  - 001: taken=!eq.
  - 100/110: taken=lt.
  - 101/111: taken=!lt.
  - 010/011: taken=0, br_illegal=1, still a normal 3-cycle transaction.
- br_illegal is valid only with br_rsp_valid; it is 0 otherwise.
- slt_result=lt.
- Backpressure: RESP stalls indefinitely; the other requester waits (no starvation, because rr flipped).
- Simultaneous requests: only one ready is high; the loser's valid must stay asserted (requester rule); it is granted next IDLE.
- Valid dropped before ready: no effect.
- Reset mid-transaction: any state → IDLE immediately; pending response is lost; requesters must reissue.

Optional Feature:
- Macro: CMP_STATS_EN.
- Defined: stat_br_cnt increments on each branch response handshake; stat_taken_cnt increments when br_taken=1 at that handshake; both saturate at 32'hFFFF_FFFF; both cleared by rst_n.
- Undefined: counters are not built; stat ports are tied to 0.

Decomposition:
- Package branch_cmp_pkg: state enum (IDLE, CMP, RESP); owner enum (OWN_BR, OWN_SLT); funct3 localparams (BEQ, BNE, BLT, BGE, BLTU, BGEU).
- One sub-module rr_arb2: 2-way round-robin grant with pointer register and reset value RR_INIT.
- Branch decode is a function in the package.

Test Plan:
- br_funct3=100, a=32'hFFFF_FFFF, b=1, cmp signed → br_rsp_valid at N+2, br_taken=1, cmp_unsign=0 during CMP. Same operands with funct3=110 → br_taken=0.
- Both valid at same cycle, RR_INIT=0 → branch granted first. slt granted after branch response handshake. Next simultaneous pair → slt first.
- slt_unsigned=1, a=5, b=5, slt_rsp_ready low 4 cycles → slt_rsp_valid and slt_result=0 held stable; br_req_ready stays 0 until handshake.
- br_funct3=010 → br_taken=0, br_illegal=1 at N+2; FSM returns IDLE.
- rst_n asserted low during CMP → all outputs 0 asynchronously. After release, no response appears; a fresh request completes normally.
- CMP_STATS_EN defined, 3 branches (BEQ equal, BNE equal, BGEU 7≥3) → stat_br_cnt=3, stat_taken_cnt=2.

Source files
------------

// File: rtl/branch_cmp_pkg.sv
// Shared types and branch decode for the comparator scheduler.
package branch_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_BR  = 1'b0,
        OWN_SLT = 1'b1
    } owner_t;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    typedef struct packed {
        logic taken;
        logic illegal;
    } br_res_t;

    // Signedness is already applied by the comparator, so BLT/BLTU and BGE/BGEU share a decode.
    function automatic br_res_t br_decode(input logic [2:0] funct3, input logic eq, input logic lt);
        br_res_t r;
        r = '0;
        case (funct3)
            BEQ:        r.taken = eq;
            BNE:        r.taken = !eq;
            BLT, BLTU:  r.taken = lt;
            BGE, BGEU:  r.taken = !lt;
            default:    r.illegal = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the requester favoured on a tie.
module rr_arb2 #(
    parameter logic RR_INIT = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    logic ptr_reg;

    always_comb begin
        grant = 2'b00;
        if (en) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = ptr_reg ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    // After any grant, favour the requester that was not served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= RR_INIT;
        end else if (en && (req != 2'b00)) begin
            ptr_reg <= ~grant[1];
        end
    end

endmodule

// File: rtl/branch_cmp_sched.sv
// Time-shares one external comparator between the branch unit and the SLT/SLTU path.
// Optional build macro CMP_STATS_EN adds saturating branch/taken counters.
module branch_cmp_sched
    import branch_cmp_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int RR_INIT = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            br_req_valid,
    output logic            br_req_ready,
    input  logic [2:0]      br_funct3,
    input  logic [XLEN-1:0] br_a,
    input  logic [XLEN-1:0] br_b,
    output logic            br_rsp_valid,
    input  logic            br_rsp_ready,
    output logic            br_taken,
    output logic            br_illegal,
    input  logic            slt_req_valid,
    output logic            slt_req_ready,
    input  logic            slt_unsigned,
    input  logic [XLEN-1:0] slt_a,
    input  logic [XLEN-1:0] slt_b,
    output logic            slt_rsp_valid,
    input  logic            slt_rsp_ready,
    output logic            slt_result,
    output logic [XLEN-1:0] cmp_a,
    output logic [XLEN-1:0] cmp_b,
    output logic            cmp_unsign,
    input  logic            cmp_eq,
    input  logic            cmp_lt,
    output logic [31:0]     stat_br_cnt,
    output logic [31:0]     stat_taken_cnt
);

    state_t          state_reg;
    owner_t          owner_reg;
    logic [XLEN-1:0] a_reg;
    logic [XLEN-1:0] b_reg;
    logic            unsign_reg;
    logic [2:0]      funct3_reg;
    logic            br_rsp_valid_reg;
    logic            br_taken_reg;
    logic            br_illegal_reg;
    logic            slt_rsp_valid_reg;
    logic            slt_result_reg;
    logic [1:0]      grant;
    logic            in_idle;
    logic            in_cmp;
    br_res_t         dec;

    assign in_idle = (state_reg == IDLE);
    assign in_cmp  = (state_reg == CMP);

    rr_arb2 #(
        .RR_INIT (RR_INIT != 0)
    ) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (in_idle),
        .req   ({slt_req_valid, br_req_valid}),
        .grant (grant)
    );

    assign br_req_ready  = grant[0];
    assign slt_req_ready = grant[1];

    // The comparator only sees operands while a compare is in flight.
    assign cmp_a      = in_cmp ? a_reg : '0;
    assign cmp_b      = in_cmp ? b_reg : '0;
    assign cmp_unsign = in_cmp & unsign_reg;

    assign dec = br_decode(funct3_reg, cmp_eq, cmp_lt);

    assign br_rsp_valid  = br_rsp_valid_reg;
    assign br_taken      = br_taken_reg;
    assign br_illegal    = br_illegal_reg;
    assign slt_rsp_valid = slt_rsp_valid_reg;
    assign slt_result    = slt_result_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= IDLE;
            owner_reg         <= OWN_BR;
            a_reg             <= '0;
            b_reg             <= '0;
            unsign_reg        <= 1'b0;
            funct3_reg        <= 3'b000;
            br_rsp_valid_reg  <= 1'b0;
            br_taken_reg      <= 1'b0;
            br_illegal_reg    <= 1'b0;
            slt_rsp_valid_reg <= 1'b0;
            slt_result_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant[0]) begin
                        a_reg      <= br_a;
                        b_reg      <= br_b;
                        unsign_reg <= br_funct3[1];
                        funct3_reg <= br_funct3;
                        owner_reg  <= OWN_BR;
                        state_reg  <= CMP;
                    end else if (grant[1]) begin
                        a_reg      <= slt_a;
                        b_reg      <= slt_b;
                        unsign_reg <= slt_unsigned;
                        owner_reg  <= OWN_SLT;
                        state_reg  <= CMP;
                    end
                end
                CMP: begin
                    if (owner_reg == OWN_BR) begin
                        br_rsp_valid_reg <= 1'b1;
                        br_taken_reg     <= dec.taken;
                        br_illegal_reg   <= dec.illegal;
                    end else begin
                        slt_rsp_valid_reg <= 1'b1;
                        slt_result_reg    <= cmp_lt;
                    end
                    state_reg <= RESP;
                end
                RESP: begin
                    // Result bits drop with valid so they never read as stale data.
                    if (br_rsp_valid_reg && br_rsp_ready) begin
                        br_rsp_valid_reg <= 1'b0;
                        br_taken_reg     <= 1'b0;
                        br_illegal_reg   <= 1'b0;
                        state_reg        <= IDLE;
                    end else if (slt_rsp_valid_reg && slt_rsp_ready) begin
                        slt_rsp_valid_reg <= 1'b0;
                        slt_result_reg    <= 1'b0;
                        state_reg         <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef CMP_STATS_EN
    logic [31:0] stat_br_cnt_reg;
    logic [31:0] stat_taken_cnt_reg;
    logic        br_hs;

    assign br_hs = br_rsp_valid_reg & br_rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_br_cnt_reg    <= '0;
            stat_taken_cnt_reg <= '0;
        end else if (br_hs) begin
            if (stat_br_cnt_reg != 32'hFFFF_FFFF) begin
                stat_br_cnt_reg <= stat_br_cnt_reg + 32'd1;
            end
            if (br_taken_reg && (stat_taken_cnt_reg != 32'hFFFF_FFFF)) begin
                stat_taken_cnt_reg <= stat_taken_cnt_reg + 32'd1;
            end
        end
    end

    assign stat_br_cnt    = stat_br_cnt_reg;
    assign stat_taken_cnt = stat_taken_cnt_reg;
`else
    assign stat_br_cnt    = '0;
    assign stat_taken_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_cmp_sched.sv
// Scoreboard bench for branch_cmp_sched: stimulus pushes expected responses, a monitor pops and compares.
module tb_branch_cmp_sched;

    localparam logic [2:0] F_BEQ  = 3'b000;
    localparam logic [2:0] F_BNE  = 3'b001;
    localparam logic [2:0] F_ILL  = 3'b010;
    localparam logic [2:0] F_BLT  = 3'b100;
    localparam logic [2:0] F_BGE  = 3'b101;
    localparam logic [2:0] F_BLTU = 3'b110;
    localparam logic [2:0] F_BGEU = 3'b111;

    logic        clk;
    logic        rst_n;
    logic        br_req_valid, br_req_ready;
    logic [2:0]  br_funct3;
    logic [31:0] br_a, br_b;
    logic        br_rsp_valid, br_rsp_ready, br_taken, br_illegal;
    logic        slt_req_valid, slt_req_ready, slt_unsigned;
    logic [31:0] slt_a, slt_b;
    logic        slt_rsp_valid, slt_rsp_ready, slt_result;
    logic [31:0] cmp_a, cmp_b;
    logic        cmp_unsign, cmp_eq, cmp_lt;
    logic [31:0] stat_br_cnt, stat_taken_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [1:0] br_q[$];
    logic       slt_q[$];

    branch_cmp_sched #(.XLEN(32), .RR_INIT(0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .br_req_valid   (br_req_valid),
        .br_req_ready   (br_req_ready),
        .br_funct3      (br_funct3),
        .br_a           (br_a),
        .br_b           (br_b),
        .br_rsp_valid   (br_rsp_valid),
        .br_rsp_ready   (br_rsp_ready),
        .br_taken       (br_taken),
        .br_illegal     (br_illegal),
        .slt_req_valid  (slt_req_valid),
        .slt_req_ready  (slt_req_ready),
        .slt_unsigned   (slt_unsigned),
        .slt_a          (slt_a),
        .slt_b          (slt_b),
        .slt_rsp_valid  (slt_rsp_valid),
        .slt_rsp_ready  (slt_rsp_ready),
        .slt_result     (slt_result),
        .cmp_a          (cmp_a),
        .cmp_b          (cmp_b),
        .cmp_unsign     (cmp_unsign),
        .cmp_eq         (cmp_eq),
        .cmp_lt         (cmp_lt),
        .stat_br_cnt    (stat_br_cnt),
        .stat_taken_cnt (stat_taken_cnt)
    );

    // External comparator model
    assign cmp_eq = (cmp_a == cmp_b);
    assign cmp_lt = cmp_unsign ? (cmp_a < cmp_b) : ($signed(cmp_a) < $signed(cmp_b));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check1(input string name, input logic act, input logic exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: compare every response handshake against the scoreboard
    always @(negedge clk) begin
        logic [1:0] be;
        logic       se;
        if (rst_n && br_rsp_valid && br_rsp_ready) begin
            if (br_q.size() == 0) begin
                check1("br_unexpected_rsp", 1'b1, 1'b0);
            end else begin
                be = br_q.pop_front();
                $display("br  rsp t=%0t taken=%b illegal=%b exp=%b/%b", $time, br_taken, br_illegal, be[1], be[0]);
                check1("br_taken", br_taken, be[1]);
                check1("br_illegal", br_illegal, be[0]);
            end
        end
        if (rst_n && slt_rsp_valid && slt_rsp_ready) begin
            if (slt_q.size() == 0) begin
                check1("slt_unexpected_rsp", 1'b1, 1'b0);
            end else begin
                se = slt_q.pop_front();
                $display("slt rsp t=%0t result=%b exp=%b", $time, slt_result, se);
                check1("slt_result", slt_result, se);
            end
        end
    end

    // Call just after a posedge; returns #1 after the accepting edge (DUT in CMP).
    task automatic br_go(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic taken, input logic ill);
        int n;
        n = 0;
        br_req_valid = 1'b1;
        br_funct3 = f3;
        br_a = a;
        br_b = b;
        @(negedge clk);
        while (!br_req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check1("br_accept", n < 50, 1'b1);
        br_q.push_back({taken, ill});
        @(posedge clk);
        #1;
        br_req_valid = 1'b0;
    endtask

    task automatic slt_go(input logic uns, input logic [31:0] a, input logic [31:0] b, input logic res);
        int n;
        n = 0;
        slt_req_valid = 1'b1;
        slt_unsigned = uns;
        slt_a = a;
        slt_b = b;
        @(negedge clk);
        while (!slt_req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check1("slt_accept", n < 50, 1'b1);
        slt_q.push_back(res);
        @(posedge clk);
        #1;
        slt_req_valid = 1'b0;
    endtask

    initial begin
        int n;
        int seen;
        rst_n = 1'b0;
        br_req_valid = 1'b0; br_funct3 = 3'b000; br_a = '0; br_b = '0; br_rsp_ready = 1'b1;
        slt_req_valid = 1'b0; slt_unsigned = 1'b0; slt_a = '0; slt_b = '0; slt_rsp_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check1("rst_br_rsp_valid", br_rsp_valid, 1'b0);
        check1("rst_slt_rsp_valid", slt_rsp_valid, 1'b0);
        check32("rst_cmp_a", cmp_a, 32'h0);
        check1("rst_cmp_unsign", cmp_unsign, 1'b0);
        check32("rst_stat_br", stat_br_cnt, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Simultaneous pair after reset: branch favoured
        fork
            br_go(F_BEQ, 32'd3, 32'd3, 1'b1, 1'b0);
            slt_go(1'b0, 32'hFFFF_FFFF, 32'd0, 1'b1);
            begin
                @(negedge clk);
                check1("pair1_br_ready", br_req_ready, 1'b1);
                check1("pair1_slt_ready", slt_req_ready, 1'b0);
            end
        join

        // Signed BLT -1 < 1 with latency and operand checks
        br_go(F_BLT, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0);
        @(negedge clk);
        check1("blt_cmp_unsign", cmp_unsign, 1'b0);
        check32("blt_cmp_a", cmp_a, 32'hFFFF_FFFF);
        check32("blt_cmp_b", cmp_b, 32'd1);
        check1("blt_valid_n1", br_rsp_valid, 1'b0);
        @(negedge clk);
        check1("blt_valid_n2", br_rsp_valid, 1'b1);
        @(posedge clk);
        #1;

        // Second simultaneous pair: slt favoured now
        fork
            br_go(F_BGE, 32'd5, 32'hFFFF_FFFE, 1'b1, 1'b0);
            slt_go(1'b1, 32'hFFFF_FFFF, 32'd0, 1'b0);
            begin
                @(negedge clk);
                check1("pair2_br_ready", br_req_ready, 1'b0);
                check1("pair2_slt_ready", slt_req_ready, 1'b1);
            end
        join

        // Unsigned compare of the same operands
        br_go(F_BLTU, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        @(negedge clk);
        check1("bltu_cmp_unsign", cmp_unsign, 1'b1);
        @(posedge clk);
        #1;

        // SLTU backpressure with a waiting branch
        slt_rsp_ready = 1'b0;
        slt_go(1'b1, 32'd5, 32'd5, 1'b0);
        fork
            br_go(F_BNE, 32'd1, 32'd2, 1'b1, 1'b0);
            begin
                @(negedge clk);
                @(negedge clk);
                for (int i = 0; i < 4; i++) begin
                    check1("bp_slt_valid", slt_rsp_valid, 1'b1);
                    check1("bp_slt_result", slt_result, 1'b0);
                    check1("bp_br_ready", br_req_ready, 1'b0);
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                slt_rsp_ready = 1'b1;
            end
        join

        // Illegal funct3
        br_go(F_ILL, 32'd0, 32'd0, 1'b0, 1'b1);
        @(negedge clk);
        check1("ill_not_early", br_illegal, 1'b0);
        @(posedge clk);
        #1;

        // Reset during CMP
        br_req_valid = 1'b1; br_funct3 = F_BLTU; br_a = 32'd1; br_b = 32'd2;
        n = 0;
        @(negedge clk);
        while (!br_req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check1("rst_accept", n < 50, 1'b1);
        @(posedge clk);
        #1;
        br_req_valid = 1'b0;
        #1;
        check1("pre_rst_cmp_unsign", cmp_unsign, 1'b1);
        rst_n = 1'b0;
        #1;
        check1("async_rst_cmp_unsign", cmp_unsign, 1'b0);
        check32("async_rst_cmp_a", cmp_a, 32'h0);
        check1("async_rst_br_rsp_valid", br_rsp_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (br_rsp_valid) seen++;
        end
        check32("lost_rsp_count", 32'(seen), 32'd0);
        @(posedge clk);
        #1;

        // Three branches after reset for the statistics counters
        br_go(F_BEQ, 32'd9, 32'd9, 1'b1, 1'b0);
        br_go(F_BNE, 32'd4, 32'd4, 1'b0, 1'b0);
        br_go(F_BGEU, 32'd7, 32'd3, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
`ifdef CMP_STATS_EN
        check32("stat_br_cnt", stat_br_cnt, 32'd3);
        check32("stat_taken_cnt", stat_taken_cnt, 32'd2);
`else
        check32("stat_br_cnt", stat_br_cnt, 32'd0);
        check32("stat_taken_cnt", stat_taken_cnt, 32'd0);
`endif

        repeat (4) @(negedge clk);
        check1("br_queue_drained", br_q.size() == 0, 1'b1);
        check1("slt_queue_drained", slt_q.size() == 0, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
